conv_rows_engine: RTL and testbench

Parametrised signed fixed-point 2-D valid convolution engine: a ROWS×K_COLS kernel slides along a ROWS×IN_COLS data window to produce N_OUT = IN_COLS−K_COLS+1 outputs. It is the configurable successor to the fixed 8×3-over-8×5 convolution stage in the gesture classifier. It computes one kernel row (K_COLS MACs) per cycle, instead of a full 24-term sum per cycle, to cut the critical path. It adds optional ReLU, optional output saturation, and atomic result commit.

---
 rtl/conv_rows_engine.sv | 104 ++++++++++
 tb/tb_conv_rows_engine.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/conv_rows_engine.sv
// conv_rows_engine: row-per-cycle signed fixed-point valid 2-D convolution with atomic result commit.
// Define CONV_SAT_EN to saturate outputs to the signed OUT_W range instead of wrapping.
module conv_rows_engine #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int ROWS    = 8,
  parameter int IN_COLS = 5,
  parameter int K_COLS  = 3,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 24,
  localparam int N_OUT  = IN_COLS - K_COLS + 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic                                 i_relu,
  input  logic [ROWS*K_COLS-1:0][DATA_W-1:0]   i_kernel,
  input  logic [ROWS*IN_COLS-1:0][DATA_W-1:0]  i_data,
  input  logic [DATA_W-1:0]                    i_bias,
  output logic [N_OUT-1:0][OUT_W-1:0]          o_weights,
  output logic                                 o_busy,
  output logic                                 o_finished
);
  localparam int RW  = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW  = N_OUT > 1 ? $clog2(N_OUT) : 1;
  localparam int DIW = ROWS * IN_COLS > 1 ? $clog2(ROWS * IN_COLS) : 1;
  localparam int KIW = ROWS * K_COLS > 1 ? $clog2(ROWS * K_COLS) : 1;
  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [ROWS*K_COLS-1:0][DATA_W-1:0]  kern;
  logic [ROWS*IN_COLS-1:0][DATA_W-1:0] data;
  logic signed [ACC_W-1:0] bias_in, bias_acc, acc, row_sum, acc_next, s;
  logic [N_OUT-1:0][OUT_W-1:0] shadow, shadow_n;
  logic [OUT_W-1:0] sat, res;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic relu_q, row_last, last, accept;
  assign bias_in  = ACC_W'($signed(i_bias)) <<< FRAC_W;
  assign row_last = row == RW'(ROWS - 1);
  assign last     = row_last && col == CW'(N_OUT - 1);
  assign accept   = state == IDLE && i_start;
  assign o_busy   = state != IDLE;
  always_comb begin
    row_sum = '0;
    for (int k = 0; k < K_COLS; k++)
      row_sum += ACC_W'((2*DATA_W)'($signed(data[DIW'(int'(row) * IN_COLS + int'(col) + k)]))
                      * (2*DATA_W)'($signed(kern[KIW'(int'(row) * K_COLS + k)])));
  end
  assign acc_next = acc + row_sum;
  assign s        = acc_next >>> FRAC_W;
`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'({(OUT_W-1){1'b1}});
  localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;
  assign sat = s > S_MAX ? S_MAX[OUT_W-1:0] : s < S_MIN ? S_MIN[OUT_W-1:0] : s[OUT_W-1:0];
`else
  assign sat = s[OUT_W-1:0];
`endif
  assign res = (relu_q && s < ACC_ZERO) ? '0 : sat;
  // the final column's result bypasses the shadow so the commit carries every entry in one edge
  always_comb begin
    shadow_n = shadow;
    for (int j = 0; j < N_OUT; j++)
      shadow_n[j] = (row_last && CW'(j) == col) ? res : shadow[j];
  end
  always_comb begin
    state_n = state == IDLE ? (i_start ? CALC : IDLE) : state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      kern       <= '0;
      data       <= '0;
      bias_acc   <= '0;
      relu_q     <= 1'b0;
      acc        <= '0;
      row        <= '0;
      col        <= '0;
      shadow     <= '0;
      o_weights  <= '0;
      o_finished <= 1'b0;
    end else begin
      o_finished <= state == CALC && last;
      if (accept) begin
        kern     <= i_kernel;
        data     <= i_data;
        relu_q   <= i_relu;
        bias_acc <= bias_in;
        acc      <= bias_in;
        row      <= '0;
        col      <= '0;
      end else if (state == CALC) begin
        shadow <= shadow_n;
        acc    <= row_last ? bias_acc : acc_next;
        row    <= row_last ? '0 : row + 1'b1;
        col    <= row_last ? col + 1'b1 : col;
        if (last) o_weights <= shadow_n;
      end
    end
  end
endmodule

// File: tb/tb_conv_rows_engine.sv
// tb_conv_rows_engine: directed and randomized checks of conv_rows_engine against an arithmetic model.
module tb_conv_rows_engine;
  localparam int DATA_W = 16, FRAC_W = 8, ROWS = 8, IN_COLS = 5, K_COLS = 3, OUT_W = 24;
  localparam int N_OUT = IN_COLS - K_COLS + 1;
  localparam int WW = N_OUT * OUT_W;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, relu = 1'b0;
  logic [ROWS*K_COLS-1:0][DATA_W-1:0]  kernel;
  logic [ROWS*IN_COLS-1:0][DATA_W-1:0] data;
  logic [DATA_W-1:0] bias;
  logic [N_OUT-1:0][OUT_W-1:0] weights;
  logic busy, finished;
  int checks = 0, failures = 0;
  conv_rows_engine dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_relu(relu),
    .i_kernel(kernel), .i_data(data), .i_bias(bias),
    .o_weights(weights), .o_busy(busy), .o_finished(finished)
  );
  always #5 clk = ~clk;
  function automatic logic [WW-1:0] model();
    logic [N_OUT-1:0][OUT_W-1:0] r;
    longint acc, s;
    for (int j = 0; j < N_OUT; j++) begin
      acc = longint'($signed(bias)) <<< FRAC_W;
      for (int rr = 0; rr < ROWS; rr++)
        for (int k = 0; k < K_COLS; k++)
          acc += longint'($signed(data[rr*IN_COLS+j+k])) * longint'($signed(kernel[rr*K_COLS+k]));
      s = acc >>> FRAC_W;
`ifdef CONV_SAT_EN
      if (s > (64'sd1 <<< (OUT_W-1)) - 1) s = (64'sd1 <<< (OUT_W-1)) - 1;
      if (s < -(64'sd1 <<< (OUT_W-1))) s = -(64'sd1 <<< (OUT_W-1));
`endif
      if (relu && s < 0) s = 0;
      r[j] = s[OUT_W-1:0];
    end
    return r;
  endfunction
  task automatic check(string tag, logic [WW-1:0] got, logic [WW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_int(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic fill(logic [15:0] d, logic [15:0] k, logic [15:0] b, logic r);
    for (int i = 0; i < ROWS*IN_COLS; i++) data[i] = d;
    for (int i = 0; i < ROWS*K_COLS; i++) kernel[i] = k;
    bias = b;
    relu = r;
  endtask
  task automatic rand_ops();
    for (int i = 0; i < ROWS*IN_COLS; i++) data[i] = 16'($urandom);
    for (int i = 0; i < ROWS*K_COLS; i++) kernel[i] = 16'($urandom);
    bias = 16'($urandom);
    relu = 1'($urandom);
  endtask
  // one start pulse; tracks finish timing, busy length and that no partial result leaks out
  task automatic run(string tag, logic [WW-1:0] exp);
    int fin_at = 0, fin_cnt = 0, busy_cnt = 0, early = 0;
    logic [WW-1:0] prev;
    @(negedge clk);
    prev = weights;
    start = 1'b1;
    for (int cyc = 1; cyc <= 28; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (finished) begin
        fin_cnt++;
        if (fin_at == 0) fin_at = cyc;
      end
      if (busy) busy_cnt++;
      if (cyc < 25 && weights !== prev) early++;
    end
    check({tag, "_weights"}, weights, exp);
    check_int({tag, "_fin_at"}, fin_at, 25);
    check_int({tag, "_fin_cnt"}, fin_cnt, 1);
    check_int({tag, "_busy_cnt"}, busy_cnt, 25);
    check_int({tag, "_partial"}, early, 0);
  endtask
  initial begin
    logic [WW-1:0] exp_a, exp_b;
    int pulses, p1, p2, fin_cnt;
    fill(16'h0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_weights", weights, '0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_finished", int'(finished), 0);
    rst_n = 1'b1;
    fill(16'h0100, 16'h0100, 16'h0000, 1'b0);
    run("ones", {3{24'h001800}});
    fill(16'h0100, 16'h0000, 16'h0080, 1'b0);
    run("bias_only", {3{24'h000080}});
    fill(16'h0100, 16'hFF00, 16'h0000, 1'b0);
    run("neg", {3{24'hFFE800}});
    fill(16'h0100, 16'hFF00, 16'h0000, 1'b1);
    run("neg_relu", {3{24'h000000}});
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
`ifdef CONV_SAT_EN
    run("max", {3{24'h7FFFFF}});
`else
    run("max", {3{24'h0067FF}});
`endif
    fill(16'h0000, 16'h0000, 16'h0000, 1'b0);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < IN_COLS; c++) data[r*IN_COLS+c] = 16'(c << FRAC_W);
      kernel[r*K_COLS] = 16'h0100;
    end
    run("index", {24'h001000, 24'h000800, 24'h000000});
    for (int t = 0; t < 6; t++) begin
      rand_ops();
      run($sformatf("rand%0d", t), model());
    end
    rand_ops();
    relu = 1'b0;
    exp_a = model();
    exp_b = '0;
    pulses = 0;
    p1 = 0;
    p2 = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 56; cyc++) begin
      @(negedge clk);
      if (cyc == 10) begin
        rand_ops();
        exp_b = model();
      end
      if (cyc == 40) start = 1'b0;
      if (finished) begin
        pulses++;
        if (p1 == 0) p1 = cyc;
        else if (p2 == 0) p2 = cyc;
      end
      if (cyc == 26) check("b2b_first", weights, exp_a);
      if (cyc == 50) check("b2b_hold", weights, exp_a);
      if (cyc == 52) check("b2b_second", weights, exp_b);
    end
    check_int("b2b_pulses", pulses, 2);
    check_int("b2b_p1", p1, 25);
    check_int("b2b_p2", p2, 51);
    rand_ops();
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_weights", weights, '0);
    check_int("abort_busy", int'(busy), 0);
    fin_cnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (finished) fin_cnt++;
    end
    check_int("abort_no_pulse", fin_cnt, 0);
    rand_ops();
    run("post_reset", model());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
